// File: rtl/aes_shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows/InvShiftRows stage (Nb = 4/6/8) with valid/ready back-pressure.
// Build option: define SHIFT_ROWS_INV_EN to honour in_inv; otherwise every block is forward-permuted.
module aes_shift_rows_pipe #(
   parameter  int NB     = 4,
   parameter  int STAGES = 1,
   localparam int W      = 32 * NB
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_inv,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [15:0]  blk_count
);

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("aes_shift_rows_pipe: STAGES must be in 1..4");
   end

   // Source byte index feeding destination byte k (byte k sits at row k%4, column k/4).
   function automatic int unsigned src_byte(input int unsigned k, input bit inv);
      int unsigned r;
      int unsigned c;
      int unsigned s;
      int unsigned sc;
      r  = k % 4;
      c  = k / 4;
      s  = (NB == 8 && r >= 2) ? r + 1 : r;
      sc = inv ? (c + NB - s) % NB : (c + s) % NB;
      return 4 * sc + r;
   endfunction

   logic [W-1:0] fwd_perm;
   logic [W-1:0] perm;

   for (genvar k = 0; k < 4 * NB; k++) begin : g_fwd
      assign fwd_perm[W-1-8*k -: 8] = in_data[W-1-8*src_byte(k, 1'b0) -: 8];
   end

`ifdef SHIFT_ROWS_INV_EN
   logic [W-1:0] inv_perm;

   for (genvar k = 0; k < 4 * NB; k++) begin : g_inv
      assign inv_perm[W-1-8*k -: 8] = in_data[W-1-8*src_byte(k, 1'b1) -: 8];
   end

   assign perm = in_inv ? inv_perm : fwd_perm;
`else
   logic unused_inv;
   assign unused_inv = in_inv;
   assign perm       = fwd_perm;
`endif

   // Each stage's load enable ripples back from out_ready, so a full pipe still
   // accepts a new block in the same cycle it hands one downstream.
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic         v;
      logic [W-1:0] d;
      logic         load;
      logic         src_v;
      logic [W-1:0] src_d;

      if (i == STAGES - 1) begin : g_tail
         assign load = !v || out_ready;
      end else begin : g_body
         assign load = !v || g_stage[i+1].load;
      end

      if (i == 0) begin : g_head
         assign src_v = in_valid;
         assign src_d = perm;
      end else begin : g_link
         assign src_v = g_stage[i-1].v;
         assign src_d = g_stage[i-1].d;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            v <= 1'b0;
            d <= '0;
         end else if (load) begin
            v <= src_v;
            if (src_v) begin
               d <= src_d;
            end
         end
      end
   end

   assign in_ready  = g_stage[0].load || reset;
   assign out_valid = g_stage[STAGES-1].v;
   assign out_data  = g_stage[STAGES-1].d;

   always_ff @(posedge clk) begin
      if (reset) begin
         blk_count <= '0;
      end else if (out_valid && out_ready) begin
         blk_count <= blk_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Bench for aes_shift_rows_pipe: three instances (NB4/S1, NB8/S3, NB6/S2) checked against a
// row/column array model of ShiftRows; expectations follow SHIFT_ROWS_INV_EN when it is defined.
module tb_aes_shift_rows_pipe;

`ifdef SHIFT_ROWS_INV_EN
   localparam bit INV_ON = 1'b1;
`else
   localparam bit INV_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic         a_reset, a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready;
   logic [127:0] a_in_data, a_out_data;
   logic [15:0]  a_blk_count;

   logic         b_reset, b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
   logic [255:0] b_in_data, b_out_data;
   logic [15:0]  b_blk_count;

   logic         c_reset, c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready;
   logic [191:0] c_in_data, c_out_data;
   logic [15:0]  c_blk_count;

   aes_shift_rows_pipe #(.NB(4), .STAGES(1)) u_a (
      .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_inv(a_in_inv), .in_data(a_in_data), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_data(a_out_data), .blk_count(a_blk_count));

   aes_shift_rows_pipe #(.NB(8), .STAGES(3)) u_b (
      .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_inv(b_in_inv), .in_data(b_in_data), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .blk_count(b_blk_count));

   aes_shift_rows_pipe #(.NB(6), .STAGES(2)) u_c (
      .clk(clk), .reset(c_reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_inv(c_in_inv), .in_data(c_in_data), .out_valid(c_out_valid),
      .out_ready(c_out_ready), .out_data(c_out_data), .blk_count(c_blk_count));

   typedef struct {
      logic [127:0] din;
      bit           inv;
      logic [127:0] exp;
   } vec_t;

   typedef struct {
      logic [255:0] d;
      bit           inv;
   } blk_t;

   logic [255:0] q_b [$];
   int           b_total_em = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [255:0] d, input int w, input int k);
      return 8'(d >> (w - 8 - 8 * k));
   endfunction

   // Model: unpack into a 4 x nb state, rotate each row by its offset, repack.
   function automatic logic [255:0] ref_perm(input logic [255:0] d, input int nb, input bit inv);
      logic [7:0]   st [4][8];
      int           offs [4];
      logic [255:0] r;
      int           w;
      int           sc;
      w = 32 * nb;
      if (nb == 8) offs = '{0, 1, 3, 4};
      else         offs = '{0, 1, 2, 3};
      for (int k = 0; k < 4 * nb; k++) st[k % 4][k / 4] = byte_of(d, w, k);
      r = '0;
      for (int row = 0; row < 4; row++) begin
         for (int c = 0; c < nb; c++) begin
            sc = inv ? (c - offs[row] + nb) % nb : (c + offs[row]) % nb;
            r  = r | (256'(st[row][sc]) << (w - 8 - 8 * (4 * c + row)));
         end
      end
      return r;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // One cycle on instance B, entered and left just after a falling edge.
   task automatic step_b(input bit iv, input logic [255:0] d, input bit inv, input bit ordy,
                         output bit acc, output bit em);
      logic [255:0] exp;
      b_in_valid  = iv;
      b_in_data   = d;
      b_in_inv    = inv;
      b_out_ready = ordy;
      #4;
      acc = b_in_valid && b_in_ready;
      em  = b_out_valid && b_out_ready;
      if (em) begin
         b_total_em++;
         if (q_b.size() == 0) begin
            chk("b_spurious_output", 1, 0);
         end else begin
            exp = q_b.pop_front();
            chk($sformatf("b_out_data_%0d", b_total_em), b_out_data, exp);
         end
      end
      if (acc) q_b.push_back(ref_perm(d, 8, inv && INV_ON));
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         tbl [8];
      blk_t         bp [10];
      bit           acc, em, have, started;
      int           acc_n, em_n, gaps, lat, first_stall, stale, bad, distinct;
      logic [255:0] asc, d, dcur;
      bit           icur;
      bit           seen [32];

      tbl[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
                 128'hd4bf5d30e0b452aeb84111f11e2798e5};
      tbl[1] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1,
                 INV_ON ? 128'hd42711aee0bf98f1b8b45de51e415230
                        : 128'hd4b411e5e0419830b8275dae1ebf52f1};
      for (int i = 2; i < 8; i++) begin
         tbl[i].din = {$urandom, $urandom, $urandom, $urandom};
         tbl[i].inv = (i % 2) == 1;
         tbl[i].exp = 128'(ref_perm(256'(tbl[i].din), 4, tbl[i].inv && INV_ON));
      end

      // Reset with in_valid asserted: must be ignored, in_ready must read 1.
      a_reset = 1; b_reset = 1; c_reset = 1;
      a_in_valid = 1; b_in_valid = 1; c_in_valid = 1;
      a_in_inv = 0; b_in_inv = 0; c_in_inv = 0;
      a_in_data = tbl[0].din; b_in_data = rnd256(); c_in_data = 192'(rnd256());
      a_out_ready = 1; b_out_ready = 1; c_out_ready = 1;
      @(negedge clk);
      #4;
      chk("a_in_ready_in_reset", a_in_ready, 1);
      chk("b_in_ready_in_reset", b_in_ready, 1);
      chk("c_in_ready_in_reset", c_in_ready, 1);
      @(negedge clk);
      a_reset = 0; b_reset = 0; c_reset = 0;
      a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
      @(posedge clk);
      #1;
      chk("a_reset_out_valid", a_out_valid, 0);
      chk("a_reset_out_data", a_out_data, 0);
      chk("a_reset_blk_count", a_blk_count, 0);
      chk("b_reset_out_valid", b_out_valid, 0);
      chk("b_reset_blk_count", b_blk_count, 0);
      chk("c_reset_out_data", c_out_data, 0);
      @(negedge clk);

      // Instance A (NB=4, STAGES=1): table-driven vectors, one block per cycle.
      for (int i = 0; i < 8; i++) begin
         a_in_valid = 1;
         a_in_data  = tbl[i].din;
         a_in_inv   = tbl[i].inv;
         a_out_ready = 1;
         @(posedge clk);
         #1;
         a_in_valid = 0;
         chk($sformatf("a_vec%0d_valid", i), a_out_valid, 1);
         chk($sformatf("a_vec%0d_data", i), a_out_data, tbl[i].exp);
         chk($sformatf("a_vec%0d_count", i), a_blk_count, i);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      chk("a_final_count", a_blk_count, 8);
      chk("a_final_idle", a_out_valid, 0);
      @(negedge clk);

      // Instance B (NB=8, STAGES=3): back-pressure with 10 blocks.
      for (int i = 0; i < 10; i++) begin
         bp[i].d   = rnd256();
         bp[i].inv = ($urandom % 2) == 1;
      end
      acc_n = 0;
      first_stall = -1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         step_b(1, bp[acc_n].d, bp[acc_n].inv, 0, acc, em);
         if (acc) acc_n++;
         else if (first_stall < 0) first_stall = cyc;
      end
      chk("b_bp_accepts", acc_n, 3);
      chk("b_bp_first_stall", first_stall, 3);
      chk("b_bp_in_ready_low", b_in_ready, 0);
      chk("b_bp_out_valid", b_out_valid, 1);
      chk("b_bp_count_held", b_blk_count, 0);
      em_n = 0; gaps = 0; started = 0;
      for (int cyc = 0; cyc < 40 && em_n < 10; cyc++) begin
         if (acc_n < 10) step_b(1, bp[acc_n].d, bp[acc_n].inv, 1, acc, em);
         else            step_b(0, '0, 1'b0, 1, acc, em);
         if (acc) acc_n++;
         if (em) begin
            em_n++;
            started = 1;
         end else if (started) begin
            gaps++;
         end
      end
      chk("b_bp_emitted", em_n, 10);
      chk("b_bp_gaps", gaps, 0);
      chk("b_bp_blk_count", b_blk_count, 10);

      // NB=8 ascending bytes, forward; held at the output for inspection.
      for (int k = 0; k < 32; k++) asc[255-8*k -: 8] = 8'(k);
      b_in_valid = 1; b_in_data = asc; b_in_inv = 0; b_out_ready = 0;
      @(posedge clk);
      #1;
      b_in_valid = 0;
      lat = 1;
      while (!b_out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("b_latency", lat, 3);
      chk("b_asc_full", b_out_data, ref_perm(asc, 8, 1'b0));
      bad = 0;
      for (int c = 0; c < 8; c++) if (byte_of(b_out_data, 256, 4 * c) != 8'(4 * c)) bad++;
      chk("b_asc_row0", bad, 0);
      chk("b_asc_r2c0", byte_of(b_out_data, 256, 2), 8'h0e);
      chk("b_asc_r2c1", byte_of(b_out_data, 256, 6), 8'h12);
      chk("b_asc_r3c0", byte_of(b_out_data, 256, 3), 8'h13);
      for (int k = 0; k < 32; k++) seen[k] = 0;
      distinct = 0;
      for (int k = 0; k < 32; k++) begin
         d = 256'(byte_of(b_out_data, 256, k));
         if (d < 32 && !seen[d[4:0]]) begin
            seen[d[4:0]] = 1;
            distinct++;
         end
      end
      chk("b_asc_unique", distinct, 32);
      @(negedge clk);
      b_out_ready = 1;
      @(posedge clk);
      #1;
      b_total_em++;
      chk("b_asc_count", b_blk_count, 11);
      @(negedge clk);

      // Alternating modes, back to back.
      for (int i = 0; i < 8; i++) begin
         step_b(1, rnd256(), (i % 2) == 1, 1, acc, em);
         chk($sformatf("b_alt_accept%0d", i), acc, 1);
      end
      for (int i = 0; i < 6; i++) step_b(0, '0, 1'b0, 1, acc, em);
      chk("b_alt_drained", q_b.size(), 0);

      // Random traffic with stable-while-stalled inputs.
      have = 0; dcur = '0; icur = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!have) begin
            have = ($urandom % 4) != 0;
            dcur = rnd256();
            icur = ($urandom % 2) == 1;
         end
         step_b(have, dcur, icur, ($urandom % 3) != 0, acc, em);
         if (acc) have = 0;
      end
      for (int i = 0; i < 8; i++) step_b(0, '0, 1'b0, 1, acc, em);
      chk("b_rand_drained", q_b.size(), 0);
      chk("b_rand_blk_count", b_blk_count, 16'(b_total_em));

      // Instance C (NB=6, STAGES=2): reset with two blocks in flight.
      c_out_ready = 0;
      for (int i = 0; i < 2; i++) begin
         c_in_valid = 1;
         c_in_data  = 192'(rnd256());
         c_in_inv   = 0;
         @(negedge clk);
      end
      c_in_valid = 0;
      #1;
      chk("c_full_valid", c_out_valid, 1);
      chk("c_full_in_ready", c_in_ready, 0);
      @(negedge clk);
      c_reset = 1; c_in_valid = 1; c_in_data = 192'(rnd256());
      #4;
      chk("c_in_ready_mid_reset", c_in_ready, 1);
      @(posedge clk);
      #1;
      chk("c_reset_out_valid", c_out_valid, 0);
      chk("c_reset_blk_count", c_blk_count, 0);
      @(negedge clk);
      c_reset = 0; c_in_valid = 0; c_out_ready = 1;
      stale = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (c_out_valid) stale++;
      end
      chk("c_no_stale", stale, 0);
      chk("c_count_after_reset", c_blk_count, 0);
      @(negedge clk);
      d = 256'(192'(rnd256()));
      c_in_valid = 1; c_in_data = 192'(d); c_in_inv = 1;
      @(posedge clk);
      #1;
      c_in_valid = 0;
      lat = 1;
      while (!c_out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("c_latency", lat, 2);
      chk("c_data", c_out_data, ref_perm(d, 6, INV_ON));
      @(posedge clk);
      #1;
      chk("c_count", c_blk_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
